// File: rtl/udma_hyper_trans_tracker.sv
// PHY-domain transfer tracker: one descriptor at a time, counts beats, stretches running/gap to SYNC_HOLD cycles.
// Abort support is compiled in with `define UDMA_HYPER_TRANS_ABORT_EN; otherwise abort_i is ignored.
module udma_hyper_trans_tracker #(
    parameter int LEN_WIDTH = 16,
    parameter int SYNC_HOLD = 4
) (
    input  logic                 phy_clk_i,
    input  logic                 rst_ni,
    input  logic                 trans_valid_i,
    output logic                 trans_ready_o,
    input  logic [LEN_WIDTH-1:0] trans_len_i,
    input  logic                 trans_proc_id_i,
    input  logic                 beat_i,
    input  logic                 abort_i,
    output logic                 running_trans_phy_o,
    output logic                 proc_id_phy_o,
    output logic [LEN_WIDTH-1:0] beat_cnt_o,
    output logic                 trans_done_o,
    output logic                 trans_aborted_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    localparam int              HW      = $clog2(SYNC_HOLD + 1);
    localparam logic [HW-1:0]   HOLD    = HW'(SYNC_HOLD);
    localparam logic [HW-1:0]   HOLD_M1 = HW'(SYNC_HOLD - 1);

    logic [1:0]           state, state_nxt;
    logic [HW-1:0]        hcnt, hcnt_nxt;
    logic [LEN_WIDTH-1:0] cnt_nxt;
    logic                 flag, flag_nxt;
    logic                 tag_nxt;
    logic                 run_exit;
    logic                 abort_act;

`ifdef UDMA_HYPER_TRANS_ABORT_EN
    assign abort_act = abort_i;
`else
    logic unused_abort;
    assign unused_abort = abort_i;
    assign abort_act    = 1'b0;
`endif

    assign trans_ready_o = (state == IDLE);

    always_comb begin
        state_nxt = state;
        hcnt_nxt  = hcnt;
        cnt_nxt   = beat_cnt_o;
        flag_nxt  = flag;
        tag_nxt   = proc_id_phy_o;
        run_exit  = 1'b0;
        case (state)
            IDLE: begin
                if (trans_valid_i) begin
                    state_nxt = RUN;
                    hcnt_nxt  = '0;
                    cnt_nxt   = trans_len_i;
                    flag_nxt  = 1'b0;
                    tag_nxt   = trans_proc_id_i;
                end
            end
            RUN: begin
                if (hcnt != HOLD) begin
                    hcnt_nxt = hcnt + 1'b1;
                end
                if (abort_act) begin
                    cnt_nxt  = '0;
                    flag_nxt = 1'b1;
                end else if (beat_i && (beat_cnt_o != '0)) begin
                    cnt_nxt = beat_cnt_o - 1'b1;
                end
                // hcnt counts completed RUN cycles, so the current one completes the hold
                if ((beat_cnt_o == '0) && (hcnt >= HOLD_M1)) begin
                    run_exit  = 1'b1;
                    state_nxt = GAP;
                    hcnt_nxt  = '0;
                end
            end
            GAP: begin
                hcnt_nxt = hcnt + 1'b1;
                if (hcnt == HOLD_M1) begin
                    state_nxt = IDLE;
                    hcnt_nxt  = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge phy_clk_i) begin
        if (!rst_ni) begin
            state               <= IDLE;
            hcnt                <= '0;
            flag                <= 1'b0;
            beat_cnt_o          <= '0;
            running_trans_phy_o <= 1'b0;
            proc_id_phy_o       <= 1'b0;
            trans_done_o        <= 1'b0;
            trans_aborted_o     <= 1'b0;
        end else begin
            state               <= state_nxt;
            hcnt                <= hcnt_nxt;
            flag                <= flag_nxt;
            beat_cnt_o          <= cnt_nxt;
            running_trans_phy_o <= (state_nxt == RUN);
            proc_id_phy_o       <= (state_nxt == RUN) ? tag_nxt : 1'b0;
            trans_done_o        <= run_exit;
            trans_aborted_o     <= run_exit & flag_nxt;
        end
    end

endmodule
